// File: rtl/access_controller.sv
// access_controller: keypad PIN entry, per-user password check with lockout,
// and confirm-twice password change with timed grant/deny/pw_set indications.
module access_controller #(
    parameter int NUM_USERS = 10,
    parameter int DIGITS = 4,
    parameter int MAX_FAILS = 3,
    parameter int SHOW_CYCLES = 16,
    parameter int LOCK_CYCLES = 1024,
    localparam int UW = NUM_USERS > 1 ? $clog2(NUM_USERS) : 1,
    localparam int CW = $clog2(DIGITS + 1),
    localparam int FW = $clog2(MAX_FAILS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [UW-1:0]         user_sel,
    input  logic                  key_valid,
    input  logic [3:0]            key_digit,
    input  logic                  key_enter,
    input  logic                  key_clear,
    input  logic                  change_req,
    output logic                  grant,
    output logic                  deny,
    output logic                  locked,
    output logic                  pw_set,
    output logic [UW-1:0]         grant_id,
    output logic [CW-1:0]         entry_count,
    output logic [4*DIGITS-1:0]   entry_digits,
    output logic [FW-1:0]         fail_count
);
    localparam int TMAX = SHOW_CYCLES > LOCK_CYCLES ? SHOW_CYCLES : LOCK_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [TW-1:0] SHOW = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] LOCK = TW'(LOCK_CYCLES - 1);

    typedef enum logic [3:0] {IDLE, ENTRY, CHECK, GRANT, DENY, LOCKOUT, NEW, CONFIRM, SET_OK} state_t;

    state_t state;
    logic [UW-1:0] cur_user;
    logic [4*DIGITS-1:0] new_pw, pw_cur, shifted;
    logic [4*DIGITS-1:0] pw [NUM_USERS];
    logic [TW-1:0] timer;
    logic [FW-1:0] fail_next;
    logic chg, dig_ok, full, user_ok, match, done, confirm_ok;

    // Out-of-range user slots find no password and therefore never match.
    always_comb begin
        pw_cur = '0;
        user_ok = 1'b0;
        for (int i = 0; i < NUM_USERS; i++) begin
            if (cur_user == UW'(i)) begin
                pw_cur = pw[i];
                user_ok = 1'b1;
            end
        end
    end

    assign dig_ok = key_valid && key_digit < 4'd10;
    assign full = entry_count == CW'(DIGITS);
    assign match = user_ok && full && entry_digits == pw_cur;
    assign confirm_ok = full && entry_digits == new_pw;
    assign shifted = (entry_digits << 4) | (4*DIGITS)'(key_digit);
    assign fail_next = fail_count == FW'(MAX_FAILS) ? fail_count : fail_count + 1'b1;
    assign done = timer == '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            grant <= 1'b0;
            deny <= 1'b0;
            locked <= 1'b0;
            pw_set <= 1'b0;
            grant_id <= '0;
            entry_count <= '0;
            entry_digits <= '0;
            fail_count <= '0;
            cur_user <= '0;
            new_pw <= '0;
            timer <= '0;
            chg <= 1'b0;
            for (int i = 0; i < NUM_USERS; i++) pw[i] <= '0;
        end else begin
            // Indications follow the state one cycle later, so they are pure flops.
            grant <= state == GRANT;
            deny <= state == DENY || state == LOCKOUT;
            locked <= state == LOCKOUT;
            pw_set <= state == SET_OK;
            timer <= done ? timer : timer - 1'b1;
            case (state)
                IDLE: if (dig_ok) begin
                    entry_digits <= (4*DIGITS)'(key_digit);
                    entry_count <= CW'(1);
                    cur_user <= user_sel;
                    state <= ENTRY;
                end
                ENTRY, NEW, CONFIRM: begin
                    if (key_clear) begin
                        entry_count <= '0;
                        entry_digits <= '0;
                        state <= IDLE;
                    end else if (key_enter) begin
                        if (state == ENTRY) state <= CHECK;
                        else if (state == NEW && full) begin
                            new_pw <= entry_digits;
                            entry_count <= '0;
                            entry_digits <= '0;
                            state <= CONFIRM;
                        end else if (state == CONFIRM) begin
                            entry_count <= '0;
                            entry_digits <= '0;
                            timer <= SHOW;
                            state <= confirm_ok ? SET_OK : DENY;
                            for (int i = 0; i < NUM_USERS; i++)
                                if (confirm_ok && cur_user == UW'(i)) pw[i] <= entry_digits;
                        end
                    end else if (dig_ok) begin
                        entry_digits <= shifted;
                        entry_count <= full ? entry_count : entry_count + 1'b1;
                    end
                end
                CHECK: begin
                    entry_count <= '0;
                    entry_digits <= '0;
                    if (match) begin
                        fail_count <= '0;
                        grant_id <= cur_user;
                        chg <= 1'b0;
                        timer <= SHOW;
                        state <= GRANT;
                    end else begin
                        fail_count <= fail_next;
                        timer <= fail_next == FW'(MAX_FAILS) ? LOCK : SHOW;
                        state <= fail_next == FW'(MAX_FAILS) ? LOCKOUT : DENY;
                    end
                end
                GRANT: begin
                    chg <= chg | change_req;
                    if (done) state <= chg || change_req ? NEW : IDLE;
                end
                DENY, SET_OK: if (done) state <= IDLE;
                LOCKOUT: if (done) begin
                    fail_count <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_access_controller.sv
// tb_access_controller: directed vector table plus hand-written multi-cycle
// sequences for lockout, password change and reset behaviour.
module tb_access_controller;
    logic clk = 1'b0, reset = 1'b0;
    logic key_valid = 1'b0, key_enter = 1'b0, key_clear = 1'b0, change_req = 1'b0;
    logic [3:0] user_sel = '0, key_digit = '0;
    logic grant, deny, locked, pw_set;
    logic [3:0] grant_id;
    logic [2:0] entry_count;
    logic [15:0] entry_digits;
    logic [1:0] fail_count;
    int checks = 0, errors = 0;

    access_controller #(
        .NUM_USERS(10), .DIGITS(4), .MAX_FAILS(3), .SHOW_CYCLES(4), .LOCK_CYCLES(20)
    ) dut (
        .clk(clk), .reset(reset), .user_sel(user_sel), .key_valid(key_valid),
        .key_digit(key_digit), .key_enter(key_enter), .key_clear(key_clear),
        .change_req(change_req), .grant(grant), .deny(deny), .locked(locked),
        .pw_set(pw_set), .grant_id(grant_id), .entry_count(entry_count),
        .entry_digits(entry_digits), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic v; logic [3:0] d; logic en; logic cl; logic [3:0] u;
        logic g; logic dn; logic lk; logic [3:0] gid; logic [2:0] cnt; logic [15:0] dig; logic [1:0] fc;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick;
        key_valid = 1'b0;
    endtask

    task automatic pin(input logic [3:0] u, input logic [15:0] val, input int n);
        user_sel = u;
        for (int i = n - 1; i >= 0; i--) press(val[4*i +: 4]);
        key_enter = 1'b1;
        tick;
        key_enter = 1'b0;
    endtask

    function automatic logic sig(input int s);
        return s == 0 ? grant : s == 1 ? deny : s == 2 ? locked : pw_set;
    endfunction

    // Bounded wait for a pulse, then measure how long it stays high.
    task automatic pulse(input string name, input int s, input int lead_exp, input int len_exp);
        int lead, len;
        lead = 0;
        len = 0;
        while (sig(s) !== 1'b1 && lead < 60) begin tick; lead++; end
        while (sig(s) === 1'b1 && len < 60) begin tick; len++; end
        check({name, "_lead"}, lead, lead_exp);
        check({name, "_len"}, len, len_exp);
    endtask

    initial begin
        int n;
        logic ign, dl;
        tbl = '{
            '{0,0,0,0,3, 0,0,0,0,0,16'h0000,0},
            '{1,0,0,0,3, 0,0,0,0,1,16'h0000,0},
            '{1,0,0,0,3, 0,0,0,0,2,16'h0000,0},
            '{1,0,0,0,3, 0,0,0,0,3,16'h0000,0},
            '{1,0,0,0,3, 0,0,0,0,4,16'h0000,0},
            '{0,0,1,0,3, 0,0,0,0,4,16'h0000,0},
            '{0,0,0,0,3, 0,0,0,3,0,16'h0000,0},
            '{0,0,0,0,3, 1,0,0,3,0,16'h0000,0},
            '{0,0,0,0,3, 1,0,0,3,0,16'h0000,0},
            '{0,0,0,0,3, 1,0,0,3,0,16'h0000,0},
            '{0,0,0,0,3, 1,0,0,3,0,16'h0000,0},
            '{0,0,0,0,3, 0,0,0,3,0,16'h0000,0},
            '{1,1,0,0,0, 0,0,0,3,1,16'h0001,0},
            '{1,2,0,0,0, 0,0,0,3,2,16'h0012,0},
            '{1,3,0,0,0, 0,0,0,3,3,16'h0123,0},
            '{1,4,0,0,0, 0,0,0,3,4,16'h1234,0},
            '{1,5,0,0,0, 0,0,0,3,4,16'h2345,0},
            '{1,10,0,0,0, 0,0,0,3,4,16'h2345,0},
            '{0,0,1,1,0, 0,0,0,3,0,16'h0000,0},
            '{0,0,0,0,0, 0,0,0,3,0,16'h0000,0},
            '{0,0,0,0,0, 0,0,0,3,0,16'h0000,0},
            '{0,0,1,0,0, 0,0,0,3,0,16'h0000,0},
            '{0,0,0,0,0, 0,0,0,3,0,16'h0000,0},
            '{0,0,0,0,0, 0,0,0,3,0,16'h0000,0}
        };
        tick;
        tick;
        reset = 1'b1;
        foreach (tbl[i]) begin
            key_valid = tbl[i].v;
            key_digit = tbl[i].d;
            key_enter = tbl[i].en;
            key_clear = tbl[i].cl;
            user_sel = tbl[i].u;
            tick;
            check($sformatf("v%0d_grant", i), grant, tbl[i].g);
            check($sformatf("v%0d_deny", i), deny, tbl[i].dn);
            check($sformatf("v%0d_locked", i), locked, tbl[i].lk);
            check($sformatf("v%0d_pw_set", i), pw_set, 0);
            check($sformatf("v%0d_grant_id", i), grant_id, tbl[i].gid);
            check($sformatf("v%0d_count", i), entry_count, tbl[i].cnt);
            check($sformatf("v%0d_digits", i), entry_digits, tbl[i].dig);
            check($sformatf("v%0d_fail", i), fail_count, tbl[i].fc);
        end
        key_valid = 1'b0;
        key_enter = 1'b0;
        key_clear = 1'b0;

        // Three wrong PINs for user 5 lead to lockout
        pin(5, 16'h1111, 4); pulse("b_deny1", 1, 2, 4); check("b_fail1", fail_count, 1);
        pin(5, 16'h2222, 4); pulse("b_deny2", 1, 2, 4); check("b_fail2", fail_count, 2);
        pin(5, 16'h3333, 4); tick; tick;
        check("b_locked", locked, 1);
        check("b_fail3", fail_count, 3);
        n = 0; ign = 1'b0; dl = 1'b0;
        while (locked === 1'b1 && n < 100) begin
            if (entry_count !== 3'd0) ign = 1'b1;
            if (deny !== 1'b1) dl = 1'b1;
            key_valid = n < 4;
            key_digit = 4'(n + 1);
            key_enter = n == 4;
            tick;
            n++;
        end
        key_valid = 1'b0;
        key_enter = 1'b0;
        check("b_lock_len", n, 20);
        check("b_keys_ignored", ign, 0);
        check("b_deny_in_lock", dl, 0);
        check("b_fail_after", fail_count, 0);
        pin(5, 16'h0000, 4); pulse("b_grant", 0, 2, 4); check("b_gid", grant_id, 5);

        // Password change for user 2
        change_req = 1'b1;
        pin(2, 16'h0000, 4); pulse("c_grant", 0, 2, 4);
        change_req = 1'b0;
        check("c_gid", grant_id, 2);
        pin(2, 16'h9876, 4); check("c_new_cleared", entry_count, 0);
        pin(2, 16'h9876, 4); pulse("c_pw_set", 3, 1, 4);
        pin(2, 16'h0000, 4); pulse("c_old_denied", 1, 2, 4); check("c_fail", fail_count, 1);
        pin(2, 16'h9876, 4); pulse("c_new_granted", 0, 2, 4); check("c_fail0", fail_count, 0);

        // Confirm mismatch keeps the current PIN
        change_req = 1'b1;
        pin(2, 16'h9876, 4); pulse("d_grant", 0, 2, 4);
        change_req = 1'b0;
        pin(2, 16'h9876, 4);
        pin(2, 16'h9875, 4); pulse("d_cfm_deny", 1, 1, 4);
        check("d_fail", fail_count, 0);
        pin(2, 16'h9875, 4); pulse("d_new_rejected", 1, 2, 4);
        pin(2, 16'h9876, 4); pulse("d_old_pin", 0, 2, 4);

        // Partial entries are mismatches even when the digits agree
        pin(0, 16'h0012, 2); pulse("e_partial", 1, 2, 4); check("e_fail1", fail_count, 1);
        pin(0, 16'h0000, 2); pulse("e_partial_zero", 1, 2, 4); check("e_fail2", fail_count, 2);
        pin(0, 16'h0000, 4); pulse("e_grant", 0, 2, 4);
        check("e_fail0", fail_count, 0);
        check("e_gid", grant_id, 0);

        // Out-of-range user, then reset during lockout
        pin(7, 16'h0000, 4); pulse("f_grant7", 0, 2, 4);
        pin(12, 16'h0000, 4); pulse("f_deny12a", 1, 2, 4); check("f_fail1", fail_count, 1);
        pin(12, 16'h0000, 4); pulse("f_deny12b", 1, 2, 4); check("f_fail2", fail_count, 2);
        pin(12, 16'h0000, 4); tick; tick;
        check("f_locked", locked, 1);
        check("f_gid_held", grant_id, 7);
        tick; tick; tick;
        reset = 1'b0;
        tick;
        check("r_grant", grant, 0);
        check("r_deny", deny, 0);
        check("r_locked", locked, 0);
        check("r_pw_set", pw_set, 0);
        check("r_gid", grant_id, 0);
        check("r_count", entry_count, 0);
        check("r_digits", entry_digits, 0);
        check("r_fail", fail_count, 0);
        reset = 1'b1;
        tick;
        check("r_locked_after", locked, 0);
        pin(2, 16'h0000, 4); pulse("f_pw_reset", 0, 2, 4);
        check("f_gid2", grant_id, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
